systolic_deskew: RTL and testbench
==================================

SYSTOLIC_DESKEW -- requirements
Module: systolic_deskew

Interface
REQ-001 SHALL have parameter DW, default 32, width of one column result.
REQ-002 SHALL have parameter DEPTH, default 4, number of row entries in the output FIFO (power of two, >=2).
REQ-003 SHALL have port i_clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port i_clr, input, 1, synchronous flush.
REQ-006 SHALL have port i_valid, input, 1, marks column-0 result of a row; column k of the same row arrives k cycles later.
REQ-007 SHALL have ports i_col0..i_col3, input, DW each, skewed column results from the 4x4 array bottom edge.
REQ-008 SHALL have port o_valid, output, 1, aligned row available.
REQ-009 SHALL have port i_ready, input, 1, downstream accepts row.
REQ-010 SHALL have port o_row, output, 4*DW, aligned row; col0 in bits [DW-1:0], col3 in the MSBs.
REQ-011 SHALL have ports o_full, o_empty, output, 1 each; o_count, output, log2(DEPTH)+1, occupancy.
REQ-012 SHALL have port o_ovf, output, 1, sticky overflow flag.

Function
REQ-013 SHALL delay i_col0 by 3, i_col1 by 2, i_col2 by 1 and i_col3 by 0 cycles, and i_valid by 3 cycles, forming an aligned row.
REQ-014 SHALL push the aligned row into the FIFO at the edge ending cycle t+3 when i_valid was high in cycle t; o_valid SHALL rise in cycle t+4 if the FIFO was empty (latency 4).
REQ-015 SHALL accept back-to-back rows (i_valid high every cycle) with throughput one row per cycle.
REQ-016 SHALL pop a row when o_valid and i_ready are both high; o_row SHALL hold stable while o_valid is high and i_ready is low.
REQ-017 SHALL, on a push while full with no pop in the same cycle, drop the incoming row, leave FIFO contents unchanged, and set o_ovf.
REQ-018 SHALL, on simultaneous push and pop when full, accept the push and leave o_count unchanged, with no overflow.
REQ-019 SHALL, on simultaneous push and pop when empty, not bypass: the row is stored and o_valid rises the next cycle.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL, on i_clr, empty the FIFO, clear the skew pipeline valids and o_ovf at the next edge; i_clr SHALL override a same-cycle push or pop.
REQ-022 SHALL ignore column inputs whose row valid is low; no X propagation into FIFO state.

Reset
REQ-023 SHALL, on i_rstn low, immediately clear all delay registers, pointers and o_ovf; o_valid=0, o_row=0, o_empty=1, o_full=0, o_count=0.
REQ-024 SHALL discard rows in flight in the skew pipeline when reset is asserted mid-operation.

Configuration
REQ-025 SHALL support macro SYSTOLIC_DESKEW_ROWCNT_EN; when defined, add output o_row_cnt (16 bits, reset 0, cleared by i_clr) that increments on every pop and wraps from 0xFFFF to 0.
REQ-026 SHALL, without SYSTOLIC_DESKEW_ROWCNT_EN, have neither the port o_row_cnt nor its counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the array dimension (4), the default DW and the row-vector typedef in the shared TPU package.
REQ-028 SHALL implement the FIFO as sub-module systolic_row_fifo; skew delay lines stay in the top.

Verification
REQ-029 Single row: i_valid at cycle 0, col0..3 = 1,2,3,4 at cycles 0..3, i_ready=1 -> o_valid in cycle 4 with o_row = {4,3,2,1}.
REQ-030 Burst: 8 back-to-back rows with i_ready=1 -> 8 consecutive o_valid cycles, rows in order, o_ovf=0.
REQ-031 Backpressure: i_ready=0 and 5 rows with DEPTH=4 -> o_full=1, o_count=4, 5th row dropped, o_ovf=1; rows 1-4 then drain intact.
REQ-032 Full plus simultaneous push/pop: o_count stays 4, new row delivered 4th after the popped row, o_ovf=0.
REQ-033 Reset during a row at cycle 2 -> outputs at reset values immediately; no o_valid after release.
REQ-034 With SYSTOLIC_DESKEW_ROWCNT_EN: 3 pops -> o_row_cnt=3; i_clr -> 0.

Source files
------------

// File: rtl/systolic_deskew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_deskew_pkg: shared constants and row type for the TPU deskew path  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package systolic_deskew_pkg;

    localparam int c_ARRAY_DIM  = 4;
    localparam int c_DEFAULT_DW = 32;

    typedef logic [c_ARRAY_DIM*c_DEFAULT_DW-1:0] row_t;

endpackage : systolic_deskew_pkg
`default_nettype wire

// File: rtl/systolic_row_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_row_fifo: synchronous row FIFO with sticky overflow, no bypass     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module systolic_row_fifo
    import systolic_deskew_pkg::*;
#(
    parameter int WIDTH = c_ARRAY_DIM*c_DEFAULT_DW,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_clr,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_ovf
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_CNT_MAX = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == c_CNT_MAX);
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: ;
            endcase
            if (i_push && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Gate the read port so the row reads zero when nothing is stored.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule : systolic_row_fifo
`default_nettype wire

// File: rtl/systolic_deskew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_deskew: realigns skewed 4x4 array column results into rows + FIFO  |
// | Option: SYSTOLIC_DESKEW_ROWCNT_EN adds the 16-bit o_row_cnt pop counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module systolic_deskew
    import systolic_deskew_pkg::*;
#(
    parameter int DW    = c_DEFAULT_DW,
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_clr,
    input  logic                        i_valid,
    input  logic [DW-1:0]               i_col0,
    input  logic [DW-1:0]               i_col1,
    input  logic [DW-1:0]               i_col2,
    input  logic [DW-1:0]               i_col3,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [c_ARRAY_DIM*DW-1:0]   o_row,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count,
`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
    output logic [15:0]                 o_row_cnt,
`endif
    output logic                        o_ovf
);

    logic [DW-1:0]               w_col_in [c_ARRAY_DIM];
    logic [c_ARRAY_DIM-2:0]      r_vld;
    logic [c_ARRAY_DIM-1:0]      w_vld_tap;
    logic [c_ARRAY_DIM*DW-1:0]   w_aligned;
    logic                        w_pop;

    assign w_col_in[0] = i_col0;
    assign w_col_in[1] = i_col1;
    assign w_col_in[2] = i_col2;
    assign w_col_in[3] = i_col3;

    // w_vld_tap[m] is the row valid as it was m cycles ago.
    assign w_vld_tap = {r_vld, i_valid};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vld <= '0;
        end else if (i_clr) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[c_ARRAY_DIM-3:0], i_valid};
        end
    end

    // Column k waits (c_ARRAY_DIM-1-k) cycles; each stage only loads while its row is valid.
    for (genvar k = 0; k < c_ARRAY_DIM; k++) begin : g_col
        localparam int c_DLY = c_ARRAY_DIM - 1 - k;
        if (c_DLY == 0) begin : g_pass
            assign w_aligned[k*DW +: DW] = w_col_in[k];
        end else begin : g_dly
            logic [DW-1:0] r_line [c_DLY];
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    for (int j = 0; j < c_DLY; j++) begin
                        r_line[j] <= '0;
                    end
                end else begin
                    if (w_vld_tap[k]) begin
                        r_line[0] <= w_col_in[k];
                    end
                    for (int j = 1; j < c_DLY; j++) begin
                        if (w_vld_tap[k+j]) begin
                            r_line[j] <= r_line[j-1];
                        end
                    end
                end
            end
            assign w_aligned[k*DW +: DW] = r_line[c_DLY-1];
        end
    end

    systolic_row_fifo #(
        .WIDTH (c_ARRAY_DIM*DW),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_clr       (i_clr),
        .i_push      (w_vld_tap[c_ARRAY_DIM-1]),
        .i_push_data (w_aligned),
        .i_pop       (i_ready),
        .o_data      (o_row),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_ovf       (o_ovf)
    );

    assign w_pop = o_valid & i_ready;

`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
    logic [15:0] r_row_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_row_cnt <= '0;
        end else if (i_clr) begin
            r_row_cnt <= '0;
        end else if (w_pop) begin
            r_row_cnt <= r_row_cnt + 16'd1;
        end
    end

    assign o_row_cnt = r_row_cnt;
`else
    logic w_unused_pop;
    assign w_unused_pop = w_pop;
`endif

endmodule : systolic_deskew
`default_nettype wire

// File: tb/tb_systolic_deskew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_systolic_deskew: directed + random bench with a queue-based row model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_systolic_deskew;
    import systolic_deskew_pkg::*;

    localparam int DW     = c_DEFAULT_DW;
    localparam int DEPTH  = 4;
    localparam int c_N    = c_ARRAY_DIM;
    localparam int c_HIST = 2048;

    logic                      i_clk   = 1'b0;
    logic                      i_rstn  = 1'b1;
    logic                      i_clr   = 1'b0;
    logic                      i_valid = 1'b0;
    logic                      i_ready = 1'b0;
    logic [DW-1:0]             i_col0  = '0;
    logic [DW-1:0]             i_col1  = '0;
    logic [DW-1:0]             i_col2  = '0;
    logic [DW-1:0]             i_col3  = '0;
    logic                      o_valid;
    logic                      o_full;
    logic                      o_empty;
    logic                      o_ovf;
    logic [c_N*DW-1:0]         o_row;
    logic [$clog2(DEPTH):0]    o_count;
`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
    logic [15:0]               o_row_cnt;
`endif

    always #5 i_clk = ~i_clk;

    systolic_deskew #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (i_clr),
        .i_valid   (i_valid),
        .i_col0    (i_col0),
        .i_col1    (i_col1),
        .i_col2    (i_col2),
        .i_col3    (i_col3),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_row     (o_row),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_count   (o_count),
`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
        .o_row_cnt (o_row_cnt),
`endif
        .o_ovf     (o_ovf)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_kill = -1;

    // Per-cycle input history; a row pushed in cycle c gathers col k from cycle c-3+k.
    logic          hv   [c_HIST];
    logic [DW-1:0] hc   [c_HIST][c_N];
    row_t          q    [$];
    logic          m_ovf    = 1'b0;
    int            m_rowcnt = 0;
    logic          use_fixed = 1'b0;
    logic [DW-1:0] fixed_val [c_N];

    task automatic chk(input string tag, input logic [c_N*DW-1:0] obs, input logic [c_N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        row_t exp_row;
        exp_row = (q.size() > 0) ? q[0] : '0;
        chk("o_valid", o_valid, q.size() > 0);
        chk("o_row",   o_row,   exp_row);
        chk("o_count", o_count, q.size());
        chk("o_full",  o_full,  q.size() == DEPTH);
        chk("o_empty", o_empty, q.size() == 0);
        chk("o_ovf",   o_ovf,   m_ovf);
`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
        chk("o_row_cnt", o_row_cnt, m_rowcnt);
`endif
    endtask

    task automatic step(input logic v, input logic rdy, input logic clr);
        logic push;
        row_t row;
        check_outputs();
        hv[cyc] = v;
        for (int k = 0; k < c_N; k++) begin
            if ((cyc - k >= 0) && hv[cyc-k]) begin
                hc[cyc][k] = use_fixed ? fixed_val[k] : DW'($urandom);
            end else begin
                hc[cyc][k] = 'x;
            end
        end
        i_valid = v;
        i_ready = rdy;
        i_clr   = clr;
        i_col0  = hc[cyc][0];
        i_col1  = hc[cyc][1];
        i_col2  = hc[cyc][2];
        i_col3  = hc[cyc][3];

        if (clr) last_kill = cyc;
        push = (cyc >= 3) && hv[cyc-3] && (last_kill < cyc - 3);
        row  = '0;
        if (push) row = {hc[cyc][3], hc[cyc-1][2], hc[cyc-2][1], hc[cyc-3][0]};
        if (clr) begin
            q.delete();
            m_ovf    = 1'b0;
            m_rowcnt = 0;
        end else begin
            if (q.size() > 0 && rdy) begin
                q.delete(0);
                m_rowcnt = (m_rowcnt + 1) % 65536;
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(row);
                else m_ovf = 1'b1;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic do_reset(input int cycles);
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_clr   = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_row",   o_row,   '0);
        chk("rst_o_empty", o_empty, 1'b1);
        chk("rst_o_full",  o_full,  1'b0);
        chk("rst_o_count", o_count, '0);
        chk("rst_o_ovf",   o_ovf,   1'b0);
        q.delete();
        m_ovf    = 1'b0;
        m_rowcnt = 0;
        for (int i = 0; i < cycles; i++) begin
            hv[cyc]   = 1'b0;
            last_kill = cyc;
            @(posedge i_clk);
            @(negedge i_clk);
            cyc++;
        end
        i_rstn = 1'b1;
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < c_HIST; i++) hv[i] = 1'b0;
        #2;
        do_reset(2);

        // Single row with known column values
        use_fixed    = 1'b1;
        fixed_val[0] = 32'd1;
        fixed_val[1] = 32'd2;
        fixed_val[2] = 32'd3;
        fixed_val[3] = 32'd4;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat3_no_valid", o_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat4_valid", o_valid, 1'b1);
        chk("lat4_row",   o_row,   {32'd4, 32'd3, 32'd2, 32'd1});
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        use_fixed = 1'b0;

        // Burst of 8 back-to-back rows
        vcnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (o_valid === 1'b1) vcnt++;
            step(i < 8, 1'b1, 1'b0);
        end
        chk("burst_valid_cycles", vcnt, 8);
        chk("burst_ovf", o_ovf, 1'b0);

        // Backpressure: fifth row overflows
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("bp_full",  o_full,  1'b1);
        chk("bp_count", o_count, 3'd4);
        chk("bp_ovf",   o_ovf,   1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        chk("bp_drained", o_empty, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_ovf", o_ovf, 1'b0);

        // Full FIFO with a push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("fpp_full_before", o_full, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("fpp_count", o_count, 3'd4);
        chk("fpp_ovf",   o_ovf,   1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);

        // Reset while a row is in the skew pipeline
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_valid", o_valid, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end

`ifdef SYSTOLIC_DESKEW_ROWCNT_EN
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        chk("rowcnt_three", o_row_cnt, 16'd3);
        step(1'b0, 1'b0, 1'b1);
        chk("rowcnt_clr", o_row_cnt, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_systolic_deskew
`default_nettype wire
